pixel_stream_bridge: RTL and testbench
======================================

# pixel_stream_bridge

Parametrised buffered bridge between the byte-wide SPI slave, a fixed-latency pixel engine and an optional UART mirror. It replaces the direct SPI→engine→SPI wiring in the top level. Incoming bytes are queued, issued to the engine under credit control, and the results are queued for the SPI return path. The design is full-duplex: each received byte returns the oldest completed result. Status counters and sticky error flags allow host-side diagnosis.

## Interface
- DATA_W, 8: data/pixel width in bits.
- DEPTH, 16: entries per FIFO (input and output); power of two, ≥2.
- PROC_LAT, 2: engine latency in cycles from proc_en to proc_out valid; ≥1.
- FILL, 0: value returned to SPI when the output FIFO is empty.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe from the SPI slave: byte received.
- rx_data  in  DATA_W  received byte, valid with rx_valid.
- tx_data  out  DATA_W  byte presented to the SPI slave din for the next transfer.
- bypass  in  1  1 = results are the input data delayed PROC_LAT cycles; the engine is unused.
- proc_en  out  1  one-cycle issue strobe to the engine.
- proc_in  out  DATA_W  pixel to the engine, valid with proc_en.
- proc_out  in  DATA_W  engine result, sampled PROC_LAT cycles after proc_en.
- mirror_en  in  1  copy every byte loaded into tx_data to the UART.
- uart_start  out  1  one-cycle transmit strobe to the UART.
- uart_data  out  DATA_W  UART byte, held stable from uart_start until the next load.
- uart_busy  in  1  UART transmitter busy.
- clr  in  1  synchronous clear of the sticky flags only.
- in_count, out_count  out  clog2(DEPTH+1)  FIFO occupancies.
- ovf, udf, uart_drop  out  1  sticky flags.

## Operation
- Reset (asynchronous, immediate): all FIFOs empty, delay line empty, and every output 0 except tx_data = FILL. Any in-flight engine results are discarded.
- Input FIFO push: on rx_valid, if in_count < DEPTH, push rx_data. If full, drop the byte and set ovf, even if a pop occurs in the same cycle.
- Issue rule: pop the input FIFO when in_count > 0 and out_count + inflight < DEPTH. Here inflight is the number of set bits in a PROC_LAT-deep valid shift register. At most one issue per cycle.
- On issue with bypass=0: proc_en=1 and proc_in=the popped byte.
- On issue with bypass=1: proc_en stays 0, and the byte enters an internal PROC_LAT-deep data delay line.
- The bypass value is sampled per issue. Mixed-mode results stay in order because latency is identical.
- Capture: when the valid shift register output is 1, write proc_out (or the delayed byte for bypass issues) to the output FIFO. Credit control guarantees the output FIFO never overflows.
- SPI return: on rx_valid, if out_count > 0, pop the head into tx_data. Otherwise load FILL and set udf.
- A capture and a pop in the same cycle on an empty output FIFO: the capture is written, and tx_data gets FILL (no fall-through).
- UART mirror states are IDLE and PEND.
  - Each tx_data load while mirror_en=1 stores the byte in the uart_data holding register and enters PEND.
  - In PEND with uart_busy=0: pulse uart_start for one cycle, then go to IDLE.
  - A new load while in PEND overwrites the holding register and sets uart_drop.
- Flags: ovf, udf and uart_drop stay set until clr or rst. If clr and a set event occur in the same cycle, set wins.
- Counters: in_count and out_count reflect registered occupancy. Simultaneous push and pop leaves a count unchanged.

## Timing
- rx_valid in cycle N → in_count increments, visible in N+1.
- Earliest proc_en is in N+1 (empty pipeline).
- The result is captured at the end of cycle N+1+PROC_LAT; out_count is visible in N+2+PROC_LAT.
- tx_data updates in the cycle after the rx_valid that pops it, and stays stable until the next rx_valid.
- Throughput is one byte per cycle sustained, provided credits are available.
- uart_start occurs at the earliest one cycle after the tx_data load. uart_busy is sampled in the same cycle uart_start would fire.

## Test plan
- **Pass-through:** DEPTH=4, PROC_LAT=2, bypass=1; push 8'h11, 8'h22, then two more rx_valid strobes after ≥5 idle cycles. Required: tx_data = 8'h11 then 8'h22; proc_en never asserted; udf=0.
- **Engine path:** bypass=0, engine model returns ~x; push 8'hA5. Required: proc_en one cycle after push with proc_in=8'hA5; the next rx_valid loads tx_data=8'h5A.
- **Underflow:** rx_valid on an empty pipeline. Required: tx_data=FILL=8'h00, udf=1; udf stays 1 until clr, then clears.
- **Backpressure and overflow:** DEPTH=4; push 9 bytes back-to-back with no pops. Required: the output FIFO holds 4, the input FIFO holds 4, bytes 9+ are dropped, ovf=1, proc_en stops once credits reach 0, and order is preserved when draining.
- **UART mirror:** mirror_en=1, uart_busy held high, two pops. Required: no uart_start, uart_drop=1, uart_data equals the second byte. Release busy → exactly one uart_start pulse.
- **Reset mid-flight:** assert rst one cycle after proc_en. Required: all counts 0, tx_data=FILL immediately, and no capture after rst deasserts.

Source files
------------

// File: rtl/pixel_stream_bridge_if.sv
`default_nettype none
// =============================================================================
// Module   : pixel_stream_bridge_if
// Brief    : SPI, engine, UART and status signals of the pixel stream bridge.
// Revision : 1.0 - initial release
// =============================================================================
interface pixel_stream_bridge_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic [DATA_W-1:0] tx_data;
    logic              bypass;
    logic              proc_en;
    logic [DATA_W-1:0] proc_in;
    logic [DATA_W-1:0] proc_out;
    logic              mirror_en;
    logic              uart_start;
    logic [DATA_W-1:0] uart_data;
    logic              uart_busy;
    logic              clr;
    logic [CNT_W-1:0]  in_count;
    logic [CNT_W-1:0]  out_count;
    logic              ovf;
    logic              udf;
    logic              uart_drop;

    modport slave (
        input  rx_valid, rx_data, bypass, proc_out, mirror_en, uart_busy, clr,
        output tx_data, proc_en, proc_in, uart_start, uart_data,
               in_count, out_count, ovf, udf, uart_drop
    );

    modport master (
        output rx_valid, rx_data, bypass, proc_out, mirror_en, uart_busy, clr,
        input  tx_data, proc_en, proc_in, uart_start, uart_data,
               in_count, out_count, ovf, udf, uart_drop
    );
endinterface
`default_nettype wire

// File: rtl/pixel_stream_bridge.sv
`default_nettype none
// =============================================================================
// Module   : pixel_stream_bridge
// Brief    : Full-duplex SPI <-> pixel engine bridge with credit-controlled issue,
//            output result queue, UART mirror and sticky diagnostics.
// Revision : 1.0 - initial release
// =============================================================================
module pixel_stream_bridge #(
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 16,
    parameter int                PROC_LAT = 2,
    parameter logic [DATA_W-1:0] FILL     = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    pixel_stream_bridge_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int SUM_W = $clog2(DEPTH + PROC_LAT + 1);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_PEND = 1'b1} uart_state_t;

    logic [DATA_W-1:0]   r_in_mem  [DEPTH];
    logic [DATA_W-1:0]   r_out_mem [DEPTH];
    logic [DATA_W-1:0]   r_dly     [PROC_LAT];
    logic [PTR_W-1:0]    r_in_wr, r_in_rd, r_out_wr, r_out_rd;
    logic [CNT_W-1:0]    r_in_count, r_out_count;
    logic [PROC_LAT-1:0] r_vld_sr, r_byp_sr;
    logic [DATA_W-1:0]   r_tx_data, r_uart_data;
    logic                r_ovf, r_udf, r_uart_drop;
    uart_state_t         r_state, w_state_next;

    logic              w_in_push, w_issue, w_credit, w_cap, w_out_pop;
    logic              w_mirror_load, w_uart_start, w_uart_drop;
    logic [SUM_W-1:0]  w_inflight;
    logic [DATA_W-1:0] w_in_head, w_cap_data, w_tx_next;

    assign w_in_head = r_in_mem[r_in_rd];
    assign w_in_push = bus.rx_valid && (r_in_count < CNT_W'(DEPTH));

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < PROC_LAT; i++) begin
            w_inflight = w_inflight + SUM_W'(r_vld_sr[i]);
        end
    end

    // Credits count results still in flight so a capture always finds room.
    assign w_credit      = (SUM_W'(r_out_count) + w_inflight) < SUM_W'(DEPTH);
    assign w_issue       = (r_in_count != '0) && w_credit;
    assign w_cap         = r_vld_sr[PROC_LAT-1];
    assign w_cap_data    = r_byp_sr[PROC_LAT-1] ? r_dly[PROC_LAT-1] : bus.proc_out;
    assign w_out_pop     = bus.rx_valid && (r_out_count != '0);
    assign w_tx_next     = w_out_pop ? r_out_mem[r_out_rd] : FILL;
    assign w_mirror_load = bus.rx_valid && bus.mirror_en;

    always_ff @(posedge clk) begin
        if (w_in_push) r_in_mem[r_in_wr] <= bus.rx_data;
        if (w_cap)     r_out_mem[r_out_wr] <= w_cap_data;
        r_dly[0] <= w_in_head;
        for (int i = 1; i < PROC_LAT; i++) begin
            r_dly[i] <= r_dly[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_wr     <= '0;
            r_in_rd     <= '0;
            r_in_count  <= '0;
            r_out_wr    <= '0;
            r_out_rd    <= '0;
            r_out_count <= '0;
            r_vld_sr    <= '0;
            r_byp_sr    <= '0;
            r_tx_data   <= FILL;
            r_uart_data <= '0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
            r_uart_drop <= 1'b0;
        end else begin
            if (w_in_push) r_in_wr <= r_in_wr + 1'b1;
            if (w_issue)   r_in_rd <= r_in_rd + 1'b1;
            r_in_count <= r_in_count + CNT_W'(w_in_push) - CNT_W'(w_issue);

            if (w_cap)     r_out_wr <= r_out_wr + 1'b1;
            if (w_out_pop) r_out_rd <= r_out_rd + 1'b1;
            r_out_count <= r_out_count + CNT_W'(w_cap) - CNT_W'(w_out_pop);

            r_vld_sr[0] <= w_issue;
            r_byp_sr[0] <= bus.bypass;
            for (int i = 1; i < PROC_LAT; i++) begin
                r_vld_sr[i] <= r_vld_sr[i-1];
                r_byp_sr[i] <= r_byp_sr[i-1];
            end

            if (bus.rx_valid)  r_tx_data   <= w_tx_next;
            if (w_mirror_load) r_uart_data <= w_tx_next;

            // A set event in the same cycle as clr takes priority.
            r_ovf       <= (bus.rx_valid && !w_in_push) || (r_ovf && !bus.clr);
            r_udf       <= (bus.rx_valid && !w_out_pop) || (r_udf && !bus.clr);
            r_uart_drop <= w_uart_drop || (r_uart_drop && !bus.clr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_uart_start = 1'b0;
        w_uart_drop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mirror_load) w_state_next = S_PEND;
            end
            S_PEND: begin
                if (!bus.uart_busy) begin
                    w_uart_start = 1'b1;
                    w_state_next = S_IDLE;
                end
                // A byte that has just been started is not lost by the overwrite.
                if (w_mirror_load) begin
                    w_state_next = S_PEND;
                    w_uart_drop  = bus.uart_busy;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.tx_data    = r_tx_data;
    assign bus.proc_en    = w_issue && !bus.bypass;
    assign bus.proc_in    = (w_issue && !bus.bypass) ? w_in_head : '0;
    assign bus.uart_start = w_uart_start;
    assign bus.uart_data  = r_uart_data;
    assign bus.in_count   = r_in_count;
    assign bus.out_count  = r_out_count;
    assign bus.ovf        = r_ovf;
    assign bus.udf        = r_udf;
    assign bus.uart_drop  = r_uart_drop;
endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_bridge.sv
`default_nettype none
// =============================================================================
// Module   : tb_pixel_stream_bridge
// Brief    : Directed bench; dut uses PROC_LAT=2, dut_bp uses PROC_LAT=8 so
//            that the credit stall and input overflow are reachable.
// Revision : 1.0 - initial release
// =============================================================================
module tb_pixel_stream_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec = 0;
    int   err = 0;
    int   pe1 = 0;
    int   pe2 = 0;
    int   us1 = 0;

    pixel_stream_bridge_if #(.DATA_W(8), .DEPTH(4)) b1 ();
    pixel_stream_bridge_if #(.DATA_W(8), .DEPTH(4)) b2 ();

    pixel_stream_bridge #(.DATA_W(8), .DEPTH(4), .PROC_LAT(2), .FILL(8'h00)) dut (
        .clk(clk), .rst(rst), .bus(b1));
    pixel_stream_bridge #(.DATA_W(8), .DEPTH(4), .PROC_LAT(8), .FILL(8'h00)) dut_bp (
        .clk(clk), .rst(rst), .bus(b2));

    always #5 clk = ~clk;

    // Engine models: result = ~pixel, PROC_LAT cycles after issue.
    logic [7:0] eng1 [2];
    logic [7:0] eng2 [8];
    always @(posedge clk) begin
        eng1[0] <= ~b1.proc_in;
        eng1[1] <= eng1[0];
        eng2[0] <= ~b2.proc_in;
        for (int i = 1; i < 8; i++) eng2[i] <= eng2[i-1];
    end
    assign b1.proc_out = eng1[1];
    assign b2.proc_out = eng2[7];

    always @(posedge clk) begin
        if (b1.proc_en === 1'b1)    pe1 <= pe1 + 1;
        if (b2.proc_en === 1'b1)    pe2 <= pe2 + 1;
        if (b1.uart_start === 1'b1) us1 <= us1 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic strobe1(input logic [7:0] d);
        b1.rx_data = d; b1.rx_valid = 1'b1;
        tick();
        b1.rx_valid = 1'b0;
    endtask

    task automatic strobe2(input logic [7:0] d);
        b2.rx_data = d; b2.rx_valid = 1'b1;
        tick();
        b2.rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        vec++; if (b1.in_count !== 3'd0) begin err++; $display("FAIL rst_in_count: got %0d exp 0", b1.in_count); end
        vec++; if (b1.out_count !== 3'd0) begin err++; $display("FAIL rst_out_count: got %0d exp 0", b1.out_count); end
        vec++; if (b1.tx_data !== 8'h00) begin err++; $display("FAIL rst_tx_data: got %h exp 00", b1.tx_data); end
        vec++; if ({b1.ovf, b1.udf, b1.uart_drop} !== 3'b000) begin err++; $display("FAIL rst_flags: got %b exp 000", {b1.ovf, b1.udf, b1.uart_drop}); end
        vec++; if ({b1.proc_en, b1.uart_start} !== 2'b00) begin err++; $display("FAIL rst_strobes: got %b exp 00", {b1.proc_en, b1.uart_start}); end
        vec++; if (b1.uart_data !== 8'h00) begin err++; $display("FAIL rst_uart_data: got %h exp 00", b1.uart_data); end
        vec++; if ({b2.in_count, b2.out_count} !== 6'd0) begin err++; $display("FAIL rst_bp_counts: got %0d/%0d exp 0/0", b2.in_count, b2.out_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_passthrough();
        int p0;
        do_reset();
        b1.bypass = 1'b1;
        p0 = pe1;
        strobe1(8'h11);
        strobe1(8'h22);
        repeat (6) tick();
        vec++; if (b1.out_count !== 3'd2) begin err++; $display("FAIL pt_out_count: got %0d exp 2", b1.out_count); end
        vec++; if (b1.in_count !== 3'd0) begin err++; $display("FAIL pt_in_count: got %0d exp 0", b1.in_count); end
        b1.clr = 1'b1;
        tick();
        b1.clr = 1'b0;
        strobe1(8'h33);
        vec++; if (b1.tx_data !== 8'h11) begin err++; $display("FAIL pt_tx_first: got %h exp 11", b1.tx_data); end
        strobe1(8'h44);
        vec++; if (b1.tx_data !== 8'h22) begin err++; $display("FAIL pt_tx_second: got %h exp 22", b1.tx_data); end
        vec++; if (b1.udf !== 1'b0) begin err++; $display("FAIL pt_udf: got %b exp 0", b1.udf); end
        tick();
        vec++; if (pe1 !== p0) begin err++; $display("FAIL pt_proc_en_count: got %0d exp %0d", pe1, p0); end
    endtask

    task automatic test_engine();
        do_reset();
        b1.bypass = 1'b0;
        strobe1(8'hA5);
        vec++; if (b1.proc_en !== 1'b1) begin err++; $display("FAIL eng_proc_en: got %b exp 1", b1.proc_en); end
        vec++; if (b1.proc_in !== 8'hA5) begin err++; $display("FAIL eng_proc_in: got %h exp a5", b1.proc_in); end
        tick();
        vec++; if (b1.proc_en !== 1'b0) begin err++; $display("FAIL eng_proc_en_pulse: got %b exp 0", b1.proc_en); end
        repeat (4) tick();
        vec++; if (b1.out_count !== 3'd1) begin err++; $display("FAIL eng_out_count: got %0d exp 1", b1.out_count); end
        strobe1(8'h00);
        vec++; if (b1.tx_data !== 8'h5A) begin err++; $display("FAIL eng_tx_data: got %h exp 5a", b1.tx_data); end
    endtask

    task automatic test_underflow();
        do_reset();
        b1.clr = 1'b1;
        strobe1(8'h77);
        b1.clr = 1'b0;
        vec++; if (b1.tx_data !== 8'h00) begin err++; $display("FAIL udf_tx_fill: got %h exp 00", b1.tx_data); end
        vec++; if (b1.udf !== 1'b1) begin err++; $display("FAIL udf_set_over_clr: got %b exp 1", b1.udf); end
        repeat (4) tick();
        vec++; if (b1.udf !== 1'b1) begin err++; $display("FAIL udf_sticky: got %b exp 1", b1.udf); end
        b1.clr = 1'b1;
        tick();
        b1.clr = 1'b0;
        vec++; if (b1.udf !== 1'b0) begin err++; $display("FAIL udf_clr: got %b exp 0", b1.udf); end
    endtask

    task automatic test_backpressure();
        int p0;
        logic [7:0] exp_a [4];
        logic [7:0] exp_b [4];
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFD; exp_a[2] = 8'hFC; exp_a[3] = 8'hFB;
        exp_b[0] = 8'hFA; exp_b[1] = 8'hF9; exp_b[2] = 8'hF8; exp_b[3] = 8'hF7;
        do_reset();
        b2.bypass = 1'b0;
        p0 = pe2;
        for (int i = 1; i <= 9; i++) strobe2(8'(i));
        vec++; if (b2.in_count !== 3'd4) begin err++; $display("FAIL bp_in_full: got %0d exp 4", b2.in_count); end
        vec++; if (b2.ovf !== 1'b1) begin err++; $display("FAIL bp_ovf: got %b exp 1", b2.ovf); end
        repeat (12) tick();
        vec++; if (b2.out_count !== 3'd4) begin err++; $display("FAIL bp_out_full: got %0d exp 4", b2.out_count); end
        vec++; if (b2.in_count !== 3'd4) begin err++; $display("FAIL bp_in_held: got %0d exp 4", b2.in_count); end
        vec++; if (pe2 - p0 !== 4) begin err++; $display("FAIL bp_issue_count: got %0d exp 4", pe2 - p0); end
        for (int j = 0; j < 4; j++) begin
            strobe2(8'h00);
            vec++; if (b2.tx_data !== exp_a[j]) begin err++; $display("FAIL bp_drain_a%0d: got %h exp %h", j, b2.tx_data, exp_a[j]); end
        end
        repeat (20) tick();
        for (int j = 0; j < 4; j++) begin
            strobe2(8'h00);
            vec++; if (b2.tx_data !== exp_b[j]) begin err++; $display("FAIL bp_drain_b%0d: got %h exp %h", j, b2.tx_data, exp_b[j]); end
        end
    endtask

    task automatic test_uart();
        int u0;
        do_reset();
        b1.bypass = 1'b1;
        b1.mirror_en = 1'b0;
        b1.uart_busy = 1'b1;
        strobe1(8'h31);
        strobe1(8'h32);
        repeat (6) tick();
        b1.mirror_en = 1'b1;
        u0 = us1;
        strobe1(8'h00);
        strobe1(8'h00);
        vec++; if (b1.tx_data !== 8'h32) begin err++; $display("FAIL uart_tx_data: got %h exp 32", b1.tx_data); end
        vec++; if (b1.uart_data !== 8'h32) begin err++; $display("FAIL uart_data_hold: got %h exp 32", b1.uart_data); end
        vec++; if (b1.uart_drop !== 1'b1) begin err++; $display("FAIL uart_drop: got %b exp 1", b1.uart_drop); end
        b1.mirror_en = 1'b0;
        tick();
        vec++; if (us1 !== u0) begin err++; $display("FAIL uart_no_start_busy: got %0d exp %0d", us1, u0); end
        b1.uart_busy = 1'b0;
        #1;
        vec++; if (b1.uart_start !== 1'b1) begin err++; $display("FAIL uart_start_level: got %b exp 1", b1.uart_start); end
        repeat (3) tick();
        vec++; if (us1 !== u0 + 1) begin err++; $display("FAIL uart_one_pulse: got %0d exp %0d", us1, u0 + 1); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        b1.bypass = 1'b0;
        strobe1(8'h5C);
        repeat (5) tick();
        strobe1(8'hA0);
        vec++; if (b1.tx_data !== 8'hA3) begin err++; $display("FAIL mid_tx_pre: got %h exp a3", b1.tx_data); end
        vec++; if (b1.proc_en !== 1'b1) begin err++; $display("FAIL mid_proc_en: got %b exp 1", b1.proc_en); end
        tick();
        #1 rst = 1'b1;
        #1;
        vec++; if (b1.tx_data !== 8'h00) begin err++; $display("FAIL mid_tx_async: got %h exp 00", b1.tx_data); end
        vec++; if ({b1.in_count, b1.out_count} !== 6'd0) begin err++; $display("FAIL mid_counts: got %0d/%0d exp 0/0", b1.in_count, b1.out_count); end
        tick();
        rst = 1'b0;
        repeat (6) tick();
        vec++; if (b1.out_count !== 3'd0) begin err++; $display("FAIL mid_no_capture: got %0d exp 0", b1.out_count); end
    endtask

    initial begin
        b1.rx_valid = 1'b0; b1.rx_data = 8'h00; b1.bypass = 1'b0; b1.mirror_en = 1'b0;
        b1.uart_busy = 1'b0; b1.clr = 1'b0;
        b2.rx_valid = 1'b0; b2.rx_data = 8'h00; b2.bypass = 1'b0; b2.mirror_en = 1'b0;
        b2.uart_busy = 1'b0; b2.clr = 1'b0;
        test_reset();
        test_passthrough();
        test_engine();
        test_underflow();
        test_backpressure();
        test_uart();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
`default_nettype wire
